// File: rtl/komandara_k10_pkg.sv
// -----------------------------------------------------------------------------
// komandara_k10_pkg
// Shared types and constants for the K10 bus arbiter slice.
//   k10_bus_src_e     : identifies which core bus owns a memory transaction
//   k10_arb_state_e   : arbiter hold state (open, or held on a stalled source)
//   K10_ARB_MAX_OUTST_LIMIT : largest supported outstanding-transaction depth
//   k10_other_src()   : returns the opposite bus source
// -----------------------------------------------------------------------------
package komandara_k10_pkg;

   typedef enum logic {
      K10_SRC_IBUS = 1'b0,
      K10_SRC_DBUS = 1'b1
   } k10_bus_src_e;

   // While a request is stalled by memory the arbiter is held on that source
   // so that the address/data toward memory cannot change under it.
   typedef enum logic [1:0] {
      K10_ARB_OPEN      = 2'd0,
      K10_ARB_HOLD_IBUS = 2'd1,
      K10_ARB_HOLD_DBUS = 2'd2
   } k10_arb_state_e;

   localparam int unsigned K10_ARB_MAX_OUTST_LIMIT = 8;

   function automatic k10_bus_src_e k10_other_src(input k10_bus_src_e src);
      return (src == K10_SRC_IBUS) ? K10_SRC_DBUS : K10_SRC_IBUS;
   endfunction

endpackage

// File: rtl/k10_bus_arb_idfifo.sv
// -----------------------------------------------------------------------------
// k10_bus_arb_idfifo
// Synchronous FIFO of bus-source IDs, one entry per in-flight memory
// transaction. Push and pop may occur in the same cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_push_src : write an ID (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_full, o_empty: occupancy flags, from registered count only
//   o_head         : oldest ID, valid when o_empty = 0
// -----------------------------------------------------------------------------
module k10_bus_arb_idfifo
   import komandara_k10_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  k10_bus_src_e i_push_src,
   input  logic         i_pop,
   output logic         o_full,
   output logic         o_empty,
   output k10_bus_src_e o_head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   k10_bus_src_e     entry_reg [DEPTH];
   logic             do_push, do_pop;

   // Full/empty come from the registered count, so a pop never opens a slot
   // for a push in the same cycle.
   assign o_full  = (count_reg == CNT_FULL);
   assign o_empty = (count_reg == '0);
   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;
   assign o_head  = entry_reg[rd_ptr_reg];

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (do_push) begin
         wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entry_reg[i] <= K10_SRC_IBUS;
         end
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (do_push) begin
            entry_reg[wr_ptr_reg] <= i_push_src;
         end
      end
   end

endmodule

// File: rtl/k10_bus_arbiter.sv
// -----------------------------------------------------------------------------
// k10_bus_arbiter
// Shares one memory port between the K10 instruction bus (read-only) and data
// bus (read/write). All three ports use req/gnt/rvalid; responses come back in
// order and are steered to the owner recorded in an ID FIFO.
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_ibus_* / o_ibus_*      : instruction bus (req, addr -> gnt, rvalid, rdata, err)
//   i_dbus_* / o_dbus_*      : data bus (req, we, addr, wdata, wstrb -> gnt, rvalid, rdata, err)
//   o_mem_* / i_mem_*        : shared memory port
//   o_unexp_rsp              : sticky flag, memory responded with nothing outstanding
// Parameters:
//   MAX_OUTSTANDING : granted-but-unanswered limit (1..8), ID FIFO depth
//   DBUS_PRIO       : 1 = dbus wins ties, 0 = round-robin on ties
// -----------------------------------------------------------------------------
module k10_bus_arbiter
   import komandara_k10_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic        DBUS_PRIO       = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ibus_req,
   input  logic [31:0] i_ibus_addr,
   output logic        o_ibus_gnt,
   output logic        o_ibus_rvalid,
   output logic [31:0] o_ibus_rdata,
   output logic        o_ibus_err,
   input  logic        i_dbus_req,
   input  logic        i_dbus_we,
   input  logic [31:0] i_dbus_addr,
   input  logic [31:0] i_dbus_wdata,
   input  logic [3:0]  i_dbus_wstrb,
   output logic        o_dbus_gnt,
   output logic        o_dbus_rvalid,
   output logic [31:0] o_dbus_rdata,
   output logic        o_dbus_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_err,
   output logic        o_unexp_rsp
);

   // Out-of-range depths are pulled back into the supported window.
   localparam int unsigned FIFO_DEPTH =
      (MAX_OUTSTANDING < 1) ? 1 :
      (MAX_OUTSTANDING > K10_ARB_MAX_OUTST_LIMIT) ? K10_ARB_MAX_OUTST_LIMIT :
      MAX_OUTSTANDING;

   k10_arb_state_e state_reg, state_next;
   k10_bus_src_e   last_src_reg, last_src_next;
   logic           unexp_reg, unexp_next;

   k10_bus_src_e   sel_src;
   logic           sel_req;
   logic           mem_req;
   logic           handshake;
   logic           fifo_full, fifo_empty;
   k10_bus_src_e   fifo_head;
   logic           rsp_valid;

   // ---------------------------------------------------------------- selection
   always_comb begin
      sel_src = K10_SRC_IBUS;
      if (state_reg == K10_ARB_HOLD_IBUS) begin
         sel_src = K10_SRC_IBUS;
      end else if (state_reg == K10_ARB_HOLD_DBUS) begin
         sel_src = K10_SRC_DBUS;
      end else if (i_ibus_req && i_dbus_req) begin
         // Round-robin: whoever was granted last loses the tie.
         sel_src = DBUS_PRIO ? K10_SRC_DBUS : k10_other_src(last_src_reg);
      end else if (i_dbus_req) begin
         sel_src = K10_SRC_DBUS;
      end
   end

   assign sel_req   = (sel_src == K10_SRC_DBUS) ? i_dbus_req : i_ibus_req;
   // Reset gating keeps every request/grant output low for the whole time
   // reset is held, not just from the next clock edge.
   assign mem_req   = sel_req & ~fifo_full & i_rst_n;
   assign handshake = mem_req & i_mem_gnt;

   assign o_ibus_gnt = handshake & (sel_src == K10_SRC_IBUS);
   assign o_dbus_gnt = handshake & (sel_src == K10_SRC_DBUS);

   // ------------------------------------------------------------- memory side
   always_comb begin
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_wstrb = '0;
      if (mem_req) begin
         o_mem_req = 1'b1;
         if (sel_src == K10_SRC_DBUS) begin
            o_mem_we    = i_dbus_we;
            o_mem_addr  = i_dbus_addr;
            o_mem_wdata = i_dbus_wdata;
            o_mem_wstrb = i_dbus_wstrb;
         end else begin
            o_mem_addr  = i_ibus_addr;
         end
      end
   end

   // ---------------------------------------------------------- hold / rr state
   always_comb begin
      state_next    = state_reg;
      last_src_next = last_src_reg;
      if (handshake) begin
         state_next    = K10_ARB_OPEN;
         last_src_next = sel_src;
      end else if (mem_req) begin
         state_next = (sel_src == K10_SRC_DBUS) ? K10_ARB_HOLD_DBUS
                                                : K10_ARB_HOLD_IBUS;
      end
   end

   // ------------------------------------------------------------ response side
   assign rsp_valid  = i_mem_rvalid & ~fifo_empty;
   assign unexp_next = unexp_reg | (i_mem_rvalid & fifo_empty);

   always_comb begin
      o_ibus_rvalid = 1'b0;
      o_ibus_rdata  = '0;
      o_ibus_err    = 1'b0;
      o_dbus_rvalid = 1'b0;
      o_dbus_rdata  = '0;
      o_dbus_err    = 1'b0;
      if (rsp_valid) begin
         if (fifo_head == K10_SRC_DBUS) begin
            o_dbus_rvalid = 1'b1;
            o_dbus_rdata  = i_mem_rdata;
            o_dbus_err    = i_mem_err;
         end else begin
            o_ibus_rvalid = 1'b1;
            o_ibus_rdata  = i_mem_rdata;
            o_ibus_err    = i_mem_err;
         end
      end
   end

   assign o_unexp_rsp = unexp_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= K10_ARB_OPEN;
         last_src_reg <= K10_SRC_IBUS;
         unexp_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_src_reg <= last_src_next;
         unexp_reg    <= unexp_next;
      end
   end

   k10_bus_arb_idfifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_idfifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (handshake),
      .i_push_src (sel_src),
      .i_pop      (rsp_valid),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty),
      .o_head     (fifo_head)
   );

endmodule

// File: tb/tb_k10_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_k10_bus_arbiter
// Directed bench for k10_bus_arbiter. Two instances share the same stimulus:
// dut (fixed dbus priority) and dut_rr (round-robin), both with two
// outstanding slots. Inputs change 1 ns after the rising edge, outputs are
// sampled 4 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_k10_bus_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_ibus_req;
   logic [31:0] i_ibus_addr;
   logic        i_dbus_req, i_dbus_we;
   logic [31:0] i_dbus_addr, i_dbus_wdata;
   logic [3:0]  i_dbus_wstrb;
   logic        i_mem_gnt, i_mem_rvalid, i_mem_err;
   logic [31:0] i_mem_rdata;

   logic        o_ibus_gnt, o_ibus_rvalid, o_ibus_err;
   logic [31:0] o_ibus_rdata;
   logic        o_dbus_gnt, o_dbus_rvalid, o_dbus_err;
   logic [31:0] o_dbus_rdata;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_wstrb;
   logic        o_unexp_rsp;

   logic        rr_ibus_gnt, rr_ibus_rvalid, rr_ibus_err;
   logic [31:0] rr_ibus_rdata;
   logic        rr_dbus_gnt, rr_dbus_rvalid, rr_dbus_err;
   logic [31:0] rr_dbus_rdata;
   logic        rr_mem_req, rr_mem_we;
   logic [31:0] rr_mem_addr, rr_mem_wdata;
   logic [3:0]  rr_mem_wstrb;
   logic        rr_unexp_rsp;

   int vectors    = 0;
   int miscompares = 0;

   always #5 i_clk = ~i_clk;

   k10_bus_arbiter #(.MAX_OUTSTANDING(2), .DBUS_PRIO(1'b1)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr),
      .o_ibus_gnt(o_ibus_gnt), .o_ibus_rvalid(o_ibus_rvalid),
      .o_ibus_rdata(o_ibus_rdata), .o_ibus_err(o_ibus_err),
      .i_dbus_req(i_dbus_req), .i_dbus_we(i_dbus_we), .i_dbus_addr(i_dbus_addr),
      .i_dbus_wdata(i_dbus_wdata), .i_dbus_wstrb(i_dbus_wstrb),
      .o_dbus_gnt(o_dbus_gnt), .o_dbus_rvalid(o_dbus_rvalid),
      .o_dbus_rdata(o_dbus_rdata), .o_dbus_err(o_dbus_err),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
      .o_unexp_rsp(o_unexp_rsp)
   );

   k10_bus_arbiter #(.MAX_OUTSTANDING(2), .DBUS_PRIO(1'b0)) dut_rr (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr),
      .o_ibus_gnt(rr_ibus_gnt), .o_ibus_rvalid(rr_ibus_rvalid),
      .o_ibus_rdata(rr_ibus_rdata), .o_ibus_err(rr_ibus_err),
      .i_dbus_req(i_dbus_req), .i_dbus_we(i_dbus_we), .i_dbus_addr(i_dbus_addr),
      .i_dbus_wdata(i_dbus_wdata), .i_dbus_wstrb(i_dbus_wstrb),
      .o_dbus_gnt(rr_dbus_gnt), .o_dbus_rvalid(rr_dbus_rvalid),
      .o_dbus_rdata(rr_dbus_rdata), .o_dbus_err(rr_dbus_err),
      .o_mem_req(rr_mem_req), .o_mem_we(rr_mem_we), .o_mem_addr(rr_mem_addr),
      .o_mem_wdata(rr_mem_wdata), .o_mem_wstrb(rr_mem_wstrb),
      .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
      .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
      .o_unexp_rsp(rr_unexp_rsp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input drive point).
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_ibus_req   = 1'b0; i_ibus_addr  = '0;
      i_dbus_req   = 1'b0; i_dbus_we    = 1'b0; i_dbus_addr = '0;
      i_dbus_wdata = '0;   i_dbus_wstrb = '0;
      i_mem_gnt    = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_err = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b0;
      idle_inputs();

      // ---------------- reset state
      #2;
      chk("rst_mem_req",  {31'd0, o_mem_req},   32'd0);
      chk("rst_ibus_gnt", {31'd0, o_ibus_gnt},  32'd0);
      chk("rst_dbus_gnt", {31'd0, o_dbus_gnt},  32'd0);
      chk("rst_unexp",    {31'd0, o_unexp_rsp}, 32'd0);
      tick(); tick();
      i_rst_n = 1'b1;

      // ---------------- both request every cycle, gnt always 1, response each cycle
      for (int k = 0; k < 4; k++) begin
         i_ibus_req = 1'b1; i_ibus_addr = 32'h0000_0100;
         i_dbus_req = 1'b1; i_dbus_we = 1'b1; i_dbus_addr = 32'h0000_0200;
         i_dbus_wdata = 32'h0000_CAFE; i_dbus_wstrb = 4'hF;
         i_mem_gnt = 1'b1; i_mem_rvalid = (k > 0);
         #3;
         chk($sformatf("prio_dgnt%0d", k), {31'd0, o_dbus_gnt}, 32'd1);
         chk($sformatf("prio_ignt%0d", k), {31'd0, o_ibus_gnt}, 32'd0);
         chk($sformatf("rr_dgnt%0d", k), {31'd0, rr_dbus_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr_ignt%0d", k), {31'd0, rr_ibus_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
         tick();
      end
      idle_inputs();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_00AB;
      #3;
      chk("prio_drain_dvalid", {31'd0, o_dbus_rvalid}, 32'd1);
      chk("rr_drain_ivalid",   {31'd0, rr_ibus_rvalid}, 32'd1);
      chk("rr_drain_idata",    rr_ibus_rdata, 32'h0000_00AB);
      tick();

      // ---------------- dbus-only read, gnt same cycle, rvalid next cycle
      idle_inputs();
      i_dbus_req = 1'b1; i_dbus_addr = 32'h8000_0010; i_mem_gnt = 1'b1;
      #3;
      chk("t1_mem_req",  {31'd0, o_mem_req},  32'd1);
      chk("t1_mem_addr", o_mem_addr, 32'h8000_0010);
      chk("t1_mem_we",   {31'd0, o_mem_we},   32'd0);
      chk("t1_dbus_gnt", {31'd0, o_dbus_gnt}, 32'd1);
      chk("t1_ibus_gnt", {31'd0, o_ibus_gnt}, 32'd0);
      tick();
      idle_inputs();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
      #3;
      chk("t1_dbus_rvalid", {31'd0, o_dbus_rvalid}, 32'd1);
      chk("t1_dbus_rdata",  o_dbus_rdata, 32'hDEAD_BEEF);
      chk("t1_ibus_rvalid", {31'd0, o_ibus_rvalid}, 32'd0);
      chk("t1_ibus_rdata",  o_ibus_rdata, 32'd0);
      chk("t1_unexp",       {31'd0, o_unexp_rsp}, 32'd0);
      tick();

      // ---------------- ibus stalled 3 cycles, dbus arrives in cycle 1
      idle_inputs();
      i_ibus_req = 1'b1; i_ibus_addr = 32'h0000_0040;
      for (int c = 0; c < 3; c++) begin
         if (c >= 1) begin
            i_dbus_req = 1'b1; i_dbus_we = 1'b1; i_dbus_addr = 32'h0000_0300;
            i_dbus_wdata = 32'h0000_0055; i_dbus_wstrb = 4'h3;
         end
         #3;
         chk($sformatf("t3_addr%0d", c),  o_mem_addr, 32'h0000_0040);
         chk($sformatf("t3_we%0d", c),    {31'd0, o_mem_we}, 32'd0);
         chk($sformatf("t3_wstrb%0d", c), {28'd0, o_mem_wstrb}, 32'd0);
         chk($sformatf("t3_dgnt%0d", c),  {31'd0, o_dbus_gnt}, 32'd0);
         tick();
      end
      i_mem_gnt = 1'b1;
      #3;
      chk("t3_ibus_gnt", {31'd0, o_ibus_gnt}, 32'd1);
      chk("t3_addr3",    o_mem_addr, 32'h0000_0040);
      tick();
      i_ibus_req = 1'b0;
      #3;
      chk("t3_dbus_gnt4", {31'd0, o_dbus_gnt}, 32'd1);
      chk("t3_addr4",     o_mem_addr, 32'h0000_0300);
      chk("t3_wdata4",    o_mem_wdata, 32'h0000_0055);
      chk("t3_wstrb4",    {28'd0, o_mem_wstrb}, 32'h3);
      chk("t3_we4",       {31'd0, o_mem_we}, 32'd1);
      tick();

      // ---------------- FIFO full (I, D outstanding): requests blocked
      i_ibus_req = 1'b1; i_dbus_req = 1'b1; i_mem_gnt = 1'b1;
      #3;
      chk("full_mem_req",  {31'd0, o_mem_req},  32'd0);
      chk("full_dbus_gnt", {31'd0, o_dbus_gnt}, 32'd0);
      chk("full_rr_req",   {31'd0, rr_mem_req}, 32'd0);
      tick();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0011; i_mem_err = 1'b0;
      #3;
      chk("rsp1_ivalid", {31'd0, o_ibus_rvalid}, 32'd1);
      chk("rsp1_idata",  o_ibus_rdata, 32'h0000_0011);
      chk("rsp1_ierr",   {31'd0, o_ibus_err}, 32'd0);
      chk("rsp1_dvalid", {31'd0, o_dbus_rvalid}, 32'd0);
      chk("rsp1_mem_req", {31'd0, o_mem_req}, 32'd0);
      tick();
      i_mem_gnt = 1'b0; i_mem_rdata = 32'h0000_0022; i_mem_err = 1'b1;
      #3;
      chk("rsp2_dvalid", {31'd0, o_dbus_rvalid}, 32'd1);
      chk("rsp2_derr",   {31'd0, o_dbus_err}, 32'd1);
      chk("rsp2_ddata",  o_dbus_rdata, 32'h0000_0022);
      chk("rsp2_ivalid", {31'd0, o_ibus_rvalid}, 32'd0);
      chk("rsp2_mem_req", {31'd0, o_mem_req}, 32'd1);
      chk("rsp2_addr",    o_mem_addr, 32'h0000_0300);
      chk("rsp2_rr_addr", rr_mem_addr, 32'h0000_0040);
      tick();
      i_mem_rvalid = 1'b0; i_mem_err = 1'b0; i_mem_gnt = 1'b1;
      #3;
      chk("hold_dgnt",    {31'd0, o_dbus_gnt},  32'd1);
      chk("hold_rr_ignt", {31'd0, rr_ibus_gnt}, 32'd1);
      tick();
      idle_inputs();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0033;
      #3;
      chk("hold_dvalid",    {31'd0, o_dbus_rvalid},  32'd1);
      chk("hold_rr_ivalid", {31'd0, rr_ibus_rvalid}, 32'd1);
      tick();

      // ---------------- response with empty FIFO
      i_mem_rdata = 32'h0000_0099;
      #3;
      chk("unexp_ivalid", {31'd0, o_ibus_rvalid}, 32'd0);
      chk("unexp_dvalid", {31'd0, o_dbus_rvalid}, 32'd0);
      tick();
      idle_inputs();
      #3;
      chk("unexp_set", {31'd0, o_unexp_rsp}, 32'd1);
      tick();
      #3;
      chk("unexp_sticky", {31'd0, o_unexp_rsp}, 32'd1);
      tick();

      // ---------------- asynchronous reset with two outstanding
      i_dbus_req = 1'b1; i_dbus_addr = 32'h0000_0500; i_mem_gnt = 1'b1;
      tick(); tick();
      i_ibus_req = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0077;
      #3;
      chk("pre_rst_dvalid", {31'd0, o_dbus_rvalid}, 32'd1);
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("arst_mem_req", {31'd0, o_mem_req},     32'd0);
      chk("arst_mem_addr", o_mem_addr,            32'd0);
      chk("arst_dgnt",    {31'd0, o_dbus_gnt},    32'd0);
      chk("arst_ignt",    {31'd0, o_ibus_gnt},    32'd0);
      chk("arst_dvalid",  {31'd0, o_dbus_rvalid}, 32'd0);
      chk("arst_unexp",   {31'd0, o_unexp_rsp},   32'd0);
      tick();
      idle_inputs();
      i_rst_n = 1'b1;
      i_mem_rvalid = 1'b1;
      #3;
      chk("post_rst_dvalid", {31'd0, o_dbus_rvalid}, 32'd0);
      chk("post_rst_ivalid", {31'd0, o_ibus_rvalid}, 32'd0);
      tick();
      idle_inputs();
      #3;
      chk("post_rst_empty", {31'd0, o_unexp_rsp}, 32'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
